// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchronizer, per-channel bounce
// filter, and registered one-cycle press/release pulses.
//
// Parameters:
//   width_p         number of independent button channels
//   stable_cycles_p cycles a new synchronized level must persist
// Ports:
//   clk_i                  board clock, rising edge
//   reset_i                synchronous, active-high reset
//   button_async_unsafe_i  raw asynchronous button levels
//   button_o               debounced, synchronized levels
//   press_o                one-cycle pulse on debounced 0->1
//   release_o              one-cycle pulse on debounced 1->0
module button_debounce #(
  parameter int width_p         = 3,
  parameter int stable_cycles_p = 120000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] button_async_unsafe_i,
  output logic [width_p-1:0] button_o,
  output logic [width_p-1:0] press_o,
  output logic [width_p-1:0] release_o
);

  localparam int cnt_w = $clog2(stable_cycles_p + 1);
  localparam logic [cnt_w-1:0] cnt_max =
    cnt_w'(stable_cycles_p - 1);

  logic [width_p-1:0] sync1;
  logic [width_p-1:0] sync2;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= button_async_unsafe_i;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < width_p; i++) begin : g_ch
    logic [cnt_w-1:0] cnt;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             differ;
    logic             done;

    assign differ = sync2[i] ^ level_q;
    // Accept on the stable_cycles_p-th consecutive differing cycle.
    assign done   = differ && (cnt == cnt_max);

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= done & sync2[i];
        release_q <= done & ~sync2[i];
        if (done) begin
          level_q <= sync2[i];
          cnt     <= '0;
        end else if (differ) begin
          cnt <= cnt + 1'b1;
        end else begin
          cnt <= '0;
        end
      end
    end

    assign button_o[i]  = level_q;
    assign press_o[i]   = press_q;
    assign release_o[i] = release_q;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Per-button input conditioning stage that sits between the board's raw push-button pins and all downstream logic (gate demos, counters, LED drivers). Each channel synchronizes its asynchronous, unsafe button level into the clock domain and filters contact bounce. It then presents a clean level plus one-cycle press and release pulses. Downstream blocks consume only these outputs, never raw pins.

## Interface
- width_p, default 3: number of independent button channels.
- stable_cycles_p, default 120000: consecutive cycles a synchronized level must differ from the current debounced level before the output changes (10 ms at 12 MHz). Legal range is 1 and up.
- clk_i  input  1  sole clock, 12 MHz board clock; all state updates on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- button_async_unsafe_i  input  width_p  raw button levels, active-high, asynchronous, not debounced.
- button_o  output  width_p  debounced, synchronized level per channel.
- press_o  output  width_p  one-cycle pulse on each debounced 0->1 transition.
- release_o  output  width_p  one-cycle pulse on each debounced 1->0 transition.

## Operation
- Channels are fully independent. Every channel has identical logic, replicated width_p times. There is no shared state between channels.
- Synchronizer: two-flop chain per channel (sync1, then sync2). Only sync2 is used by the filter. Raw inputs feed nothing else.
- Filter state per channel:
  - debounced level, driven out as button_o;
  - counter, width $clog2(stable_cycles_p+1) bits, unsigned.
- Filter update each rising edge (reset_i low):
  - If sync2 equals button_o: counter <= 0.
  - If sync2 differs and counter == stable_cycles_p-1: button_o <= sync2, counter <= 0.
  - If sync2 differs and the counter is below that value: counter <= counter+1.
- The counter never exceeds stable_cycles_p-1 and never wraps.
- Any single cycle of agreement between sync2 and button_o restarts the count from 0. A bounce must persist for stable_cycles_p full cycles to be accepted.
- Pulses are registered:
  - press_o[i] is 1 for exactly the one cycle in which button_o[i] first reads 1 after being 0.
  - release_o[i] is the same for the 1->0 transition.
  - press_o and release_o are never high together on the same channel.
  - No pulse is produced without a button_o change.
- Reset (reset_i high at a rising edge): sync1, sync2, button_o, counters, press_o and release_o are all cleared to 0 at that edge. Reset has priority over every other update.
- Reset mid-count discards the partial count.
- Reset while a button is held:
  - button_o stays 0 during reset.
  - No release_o pulse is generated by the reset.
  - After release of reset, the held button is re-qualified as a fresh press, including a press_o pulse.

## Timing
- All outputs come from flops. There is no combinational path from any input to any output.
- Reset values: button_o = 0, press_o = 0, release_o = 0.
- Latency: raw level changes and then holds steady. Edge 0 is the first rising edge that samples the new raw level into sync1.
  - sync2 holds the new level after edge 1.
  - button_o and the matching pulse change at edge stable_cycles_p+1, so first visible in the cycle after that edge.
  - Total is stable_cycles_p+2 edges, counting edge 0.
- Minimum accepted pulse width at sync2 is stable_cycles_p cycles. A sync2 deviation of stable_cycles_p-1 cycles or fewer produces no output change and no pulse.
- A release following a press needs its own full stable_cycles_p qualification. The minimum spacing between press_o and release_o on one channel is stable_cycles_p cycles.
- Simultaneous transitions on several channels produce simultaneous, independent pulses.

## Test plan
Run with width_p=3, stable_cycles_p=4 unless noted.
- Clean press. After reset, raise button_async_unsafe_i[0] and hold.
  - Required: button_o[0] 0->1 and press_o[0] high for exactly 1 cycle, 6 edges after the first sampling edge.
  - Required: button_o[2:1] and all release_o stay 0.
- Bounce rejection. On channel 1, drive toggles of 1, 2 and 3 cycles high separated by 1-cycle lows, then hold low.
  - Required: button_o[1], press_o[1] and release_o[1] stay 0 throughout.
  - Then hold high for 4+ cycles. Required: exactly one press_o[1] pulse.
- Release and boundary.
  - With button_o[2]=1, drop the input low for exactly 3 stable sync2 cycles, then return high. Required: no change.
  - Then drop low for exactly 4 cycles. Required: button_o[2] 1->0 with a single release_o[2] pulse.
- Simultaneous channels.
  - Raise inputs 0 and 2 on the same edge. Required: press_o = 3'b101 in one cycle.
  - Then release channel 0 only. Required: release_o = 3'b001 and button_o = 3'b100.
- Reset mid-count and held button.
  - Assert reset_i after 2 counted cycles on channel 0. Required: all outputs 0 on the next cycle, with no pulses.
  - Deassert reset_i with the input still high. Required: press_o[0] fires 6 edges after the first post-reset edge.
- Long parameter sanity. Use width_p=1, stable_cycles_p=120000 with a 119999-cycle glitch followed by a steady hold.
  - Required: the glitch is ignored.
  - Required: the output rises 120002 edges into the hold.
